// File: rtl/frac_delay_buffer_pkg.sv
// Shared types and constants for the fractional delay line: FSM state encoding
// and the helper that computes the largest total delay the ring can serve.
package delay_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        RD_A = 3'd2,
        RD_B = 3'd3,
        MIX  = 3'd4,
        DONE = 3'd5
    } state_e;

    // Two slots are reserved so that tap B (one sample older than tap A) never
    // lands on the slot being written for the current frame.
    function automatic logic [63:0] clamp_limit(input int buf_depth, input int frac_width);
        return 64'(buf_depth - 2) << frac_width;
    endfunction

endpackage

// File: rtl/frac_delay_buffer_lerp.sv
// Linear interpolation between two adjacent delay taps:
// y = a + floor((b - a) * frac / 2^FRAC_WIDTH).
module frac_lerp #(
    parameter int PKT_WIDTH  = 16,
    parameter int FRAC_WIDTH = 8
) (
    input  logic [PKT_WIDTH-1:0]  a_i,
    input  logic [PKT_WIDTH-1:0]  b_i,
    input  logic [FRAC_WIDTH-1:0] frac_i,
    output logic [PKT_WIDTH-1:0]  y_o
);

    localparam int PROD_W = PKT_WIDTH + FRAC_WIDTH + 2;

    logic signed [PKT_WIDTH:0] diff;
    logic signed [PROD_W-1:0]  prod;
    logic signed [PROD_W-1:0]  step;

    // The result always lies between a and b, so truncation cannot overflow.
    always_comb begin
        diff = $signed({b_i[PKT_WIDTH-1], b_i}) - $signed({a_i[PKT_WIDTH-1], a_i});
        prod = PROD_W'(diff) * PROD_W'($signed({1'b0, frac_i}));
        step = prod >>> FRAC_WIDTH;
        y_o  = a_i + PKT_WIDTH'(step);
    end

endmodule

// File: rtl/frac_delay_buffer.sv
// Multichannel fractional delay line: each frame is written into a per-channel
// ring buffer and two adjacent past samples are read back and interpolated.
module frac_delay_buffer
    import delay_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int PKT_WIDTH  = 16,
    parameter int BUF_DEPTH  = 4096,
    parameter int ADDR_WIDTH = $clog2(BUF_DEPTH),
    parameter int FRAC_WIDTH = 8,
    parameter int AVG_DELAY  = 882
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CH*PKT_WIDTH-1:0]    pkt_i,
    input  logic                           pkt_valid_i,
    output logic                           pkt_ready_o,
    input  logic [ADDR_WIDTH+FRAC_WIDTH-1:0] delay_i,
    output logic [NUM_CH*PKT_WIDTH-1:0]    pkt_delayed_o,
    output logic                           pkt_delayed_valid_o
);

    localparam int CW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int RAW      = CW + ADDR_WIDTH;
    localparam int DW       = ADDR_WIDTH + FRAC_WIDTH + 1;
    localparam int FRAME_W  = NUM_CH * PKT_WIDTH;

    localparam logic [DW-1:0]         D_MAX    = DW'(clamp_limit(BUF_DEPTH, FRAC_WIDTH));
    localparam logic [DW-1:0]         D_BASE   = DW'(AVG_DELAY) << FRAC_WIDTH;
    localparam logic [ADDR_WIDTH:0]   FILL_MAX = (ADDR_WIDTH + 1)'(BUF_DEPTH);
    localparam logic [CW-1:0]         LAST_CH  = CW'(NUM_CH - 1);

    if (BUF_DEPTH < 2 || (BUF_DEPTH & (BUF_DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "frac_delay_buffer: BUF_DEPTH must be a power of two");
    end
    if ((1 << ADDR_WIDTH) != BUF_DEPTH) begin : g_bad_addr
        $fatal(1, "frac_delay_buffer: ADDR_WIDTH must equal log2(BUF_DEPTH)");
    end
    if (AVG_DELAY > BUF_DEPTH - 2) begin : g_bad_avg
        $fatal(1, "frac_delay_buffer: AVG_DELAY must not exceed BUF_DEPTH-2");
    end

    state_e                  state_q, state_d;
    logic [CW-1:0]           ch_q, ch_d;
    logic [ADDR_WIDTH-1:0]   wp_q, wp_d;
    logic [ADDR_WIDTH:0]     fill_q, fill_d;
    logic [ADDR_WIDTH-1:0]   d_int_q, d_int_d;
    logic [FRAC_WIDTH-1:0]   frac_q, frac_d;
    logic [FRAME_W-1:0]      pkt_q, pkt_d;
    logic [FRAME_W-1:0]      frame_q, frame_d;
    logic [FRAME_W-1:0]      out_q, out_d;
    logic [PKT_WIDTH-1:0]    tap_a_q, tap_a_d;
    logic                    valid_q, valid_d;

    logic                    accept;
    logic                    last_ch;
    logic [DW-1:0]           d_total;
    logic [DW-1:0]           d_clamped;
    logic [ADDR_WIDTH-1:0]   d_int_new;
    logic [FRAC_WIDTH-1:0]   frac_new;
    logic [ADDR_WIDTH-1:0]   rd_a_idx;
    logic [ADDR_WIDTH-1:0]   rd_b_idx;
    logic                    a_ok;
    logic                    b_ok;
    logic [PKT_WIDTH-1:0]    cur_sample;
    logic [PKT_WIDTH-1:0]    tap_b;
    logic [PKT_WIDTH-1:0]    lerp_y;

    logic                    ram_we;
    logic [RAW-1:0]          ram_addr;
    logic [PKT_WIDTH-1:0]    ram_wdata;
    logic [PKT_WIDTH-1:0]    ram_rdata;
    logic [PKT_WIDTH-1:0]    mem [NUM_CH*BUF_DEPTH];

    assign accept  = pkt_valid_i && pkt_ready_o;
    assign last_ch = (ch_q == LAST_CH);

    assign pkt_delayed_o       = out_q;
    assign pkt_delayed_valid_o = valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = WR;
            WR:      state_d = RD_A;
            RD_A:    state_d = RD_B;
            RD_B:    state_d = MIX;
            MIX:     state_d = last_ch ? DONE : WR;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pkt_ready_o = 1'b0;
        ram_we      = 1'b0;
        ram_addr    = '0;
        ram_wdata   = '0;
        unique case (state_q)
            IDLE: pkt_ready_o = 1'b1;
            WR: begin
                ram_we    = 1'b1;
                ram_addr  = {ch_q, wp_q};
                ram_wdata = cur_sample;
            end
            RD_A:    ram_addr = {ch_q, rd_a_idx};
            RD_B:    ram_addr = {ch_q, rd_b_idx};
            default: ;
        endcase
    end

    // Total delay is fixed at accept time so later delay_i changes cannot
    // disturb a frame that is still being processed.
    always_comb begin
        d_total   = D_BASE + DW'(delay_i);
        d_clamped = (d_total > D_MAX) ? D_MAX : d_total;
        d_int_new = ADDR_WIDTH'(d_clamped >> FRAC_WIDTH);
        frac_new  = FRAC_WIDTH'(d_clamped);
    end

    // A tap older than the number of frames written since reset would read
    // stale or uninitialised RAM, so it is forced to silence instead.
    always_comb begin
        cur_sample = pkt_q[ch_q*PKT_WIDTH +: PKT_WIDTH];
        rd_a_idx   = wp_q - d_int_q;
        rd_b_idx   = rd_a_idx - ADDR_WIDTH'(1);
        a_ok       = ({1'b0, d_int_q} <= fill_q);
        b_ok       = (({1'b0, d_int_q} + (ADDR_WIDTH + 1)'(1)) <= fill_q);
        tap_b      = b_ok ? ram_rdata : '0;
    end

    frac_lerp #(
        .PKT_WIDTH  (PKT_WIDTH),
        .FRAC_WIDTH (FRAC_WIDTH)
    ) u_lerp (
        .a_i    (tap_a_q),
        .b_i    (tap_b),
        .frac_i (frac_q),
        .y_o    (lerp_y)
    );

    always_comb begin
        ch_d    = ch_q;
        wp_d    = wp_q;
        fill_d  = fill_q;
        d_int_d = d_int_q;
        frac_d  = frac_q;
        pkt_d   = pkt_q;
        frame_d = frame_q;
        out_d   = out_q;
        tap_a_d = tap_a_q;
        valid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    pkt_d   = pkt_i;
                    d_int_d = d_int_new;
                    frac_d  = frac_new;
                    ch_d    = '0;
                end
            end
            RD_B: tap_a_d = a_ok ? ram_rdata : '0;
            MIX: begin
                frame_d[ch_q*PKT_WIDTH +: PKT_WIDTH] = lerp_y;
                // The output register is loaded together with the pulse so the
                // whole frame changes in a single cycle.
                if (last_ch) begin
                    out_d   = frame_d;
                    valid_d = 1'b1;
                end else begin
                    ch_d = ch_q + CW'(1);
                end
            end
            DONE: begin
                wp_d   = wp_q + ADDR_WIDTH'(1);
                fill_d = (fill_q == FILL_MAX) ? fill_q : fill_q + (ADDR_WIDTH + 1)'(1);
                ch_d   = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_q    <= '0;
            wp_q    <= '0;
            fill_q  <= '0;
            d_int_q <= '0;
            frac_q  <= '0;
            pkt_q   <= '0;
            frame_q <= '0;
            out_q   <= '0;
            tap_a_q <= '0;
            valid_q <= 1'b0;
        end else begin
            ch_q    <= ch_d;
            wp_q    <= wp_d;
            fill_q  <= fill_d;
            d_int_q <= d_int_d;
            frac_q  <= frac_d;
            pkt_q   <= pkt_d;
            frame_q <= frame_d;
            out_q   <= out_d;
            tap_a_q <= tap_a_d;
            valid_q <= valid_d;
        end
    end

    // Single-port synchronous RAM with no reset so it maps onto block memory.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

endmodule

// File: tb/tb_frac_delay_buffer.sv
// Randomised bench for frac_delay_buffer: a frame-history model predicts the
// handshake timing and interpolated output, compared against the DUT each cycle.
module tb_frac_delay_buffer;

    localparam int NUM_CH    = 2;
    localparam int PW        = 16;
    localparam int BUF_DEPTH = 4096;
    localparam int AW        = 12;
    localparam int FW        = 8;
    localparam int AVG       = 882;
    localparam int DLYW      = AW + FW;
    localparam int FBITS     = NUM_CH * PW;
    localparam int FRAME_CYC = 4 * NUM_CH + 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [FBITS-1:0]  pkt_i = '0;
    logic              pkt_valid_i = 1'b0;
    logic              pkt_ready_o;
    logic [DLYW-1:0]   delay_i = '0;
    logic [FBITS-1:0]  pkt_delayed_o;
    logic              pkt_delayed_valid_o;

    int     n_checks = 0;
    int     n_fail = 0;
    int     acc_cnt = 0;
    int     pulse_cnt = 0;
    int     phase = 0;
    longint cyc = 0;
    longint last_pulse_cyc = -1;

    int               left = 0;
    logic [FBITS-1:0] hist[$];
    logic [FBITS-1:0] pending = '0;
    logic [FBITS-1:0] out_exp = '0;

    frac_delay_buffer #(
        .NUM_CH     (NUM_CH),
        .PKT_WIDTH  (PW),
        .BUF_DEPTH  (BUF_DEPTH),
        .ADDR_WIDTH (AW),
        .FRAC_WIDTH (FW),
        .AVG_DELAY  (AVG)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .pkt_i               (pkt_i),
        .pkt_valid_i         (pkt_valid_i),
        .pkt_ready_o         (pkt_ready_o),
        .delay_i             (delay_i),
        .pkt_delayed_o       (pkt_delayed_o),
        .pkt_delayed_valid_o (pkt_delayed_valid_o)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, actual, expected);
        end
    endtask

    function automatic int sample_of(input logic [FBITS-1:0] f, input int c);
        logic [PW-1:0] s;
        s = f[c*PW +: PW];
        return int'($signed(s));
    endfunction

    function automatic logic [FBITS-1:0] pack2(input int c0, input int c1);
        logic [PW-1:0] s0;
        logic [PW-1:0] s1;
        s0 = c0[PW-1:0];
        s1 = c1[PW-1:0];
        return {s1, s0};
    endfunction

    // Output of frame n: interpolate between the frames d and d+1 back in
    // history; anything older than the first frame since reset is silence.
    function automatic logic [FBITS-1:0] model_frame(input int n, input logic [DLYW-1:0] dly);
        longint           dtot;
        longint           dmax;
        int               dint;
        int               fr;
        int               a;
        int               b;
        int               y;
        logic [FBITS-1:0] res;
        dtot = longint'(AVG) * (1 << FW) + longint'(dly);
        dmax = longint'(BUF_DEPTH - 2) * (1 << FW);
        if (dtot > dmax) dtot = dmax;
        dint = int'(dtot / (1 << FW));
        fr   = int'(dtot % (1 << FW));
        res  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            a = (dint <= n) ? sample_of(hist[n - dint], c) : 0;
            b = (dint + 1 <= n) ? sample_of(hist[n - dint - 1], c) : 0;
            y = a + (((b - a) * fr) >>> FW);
            res[c*PW +: PW] = y[PW-1:0];
        end
        return res;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rst) begin
                left      = 0;
                out_exp   = '0;
                pulse_cnt = 0;
                hist.delete();
            end else if (left > 0) begin
                left--;
                if (left == 1) begin
                    out_exp = pending;
                    pulse_cnt++;
                end
            end else if (pkt_valid_i) begin
                hist.push_back(pkt_i);
                pending = model_frame(hist.size() - 1, delay_i);
                left    = FRAME_CYC - 1;
                acc_cnt++;
            end

            check_output("ready", 64'(pkt_ready_o), 64'(left == 0));
            check_output("valid", 64'(pkt_delayed_valid_o), 64'(left == 1));
            check_output("frame", 64'(pkt_delayed_o), 64'(out_exp));

            if (left == 1) begin
                if (phase == 1 && pulse_cnt == 882) check_output("impulse_882", 64'(pkt_delayed_o), 64'h0);
                if (phase == 1 && pulse_cnt == 883) check_output("impulse_883", 64'(pkt_delayed_o), 64'hFC18_03E8);
                if (phase == 2 && pulse_cnt == 900) check_output("ramp_ch0_900", 64'(pkt_delayed_o[PW-1:0]), 64'd1650);
                if (phase == 3) check_output("startup_zero", 64'(pkt_delayed_o), 64'h0);
            end
            if (phase == 4 && pkt_delayed_valid_o) begin
                if (last_pulse_cyc >= 0) check_output("accept_spacing", 64'(cyc - last_pulse_cyc), 64'(FRAME_CYC));
                last_pulse_cyc = cyc;
            end
        end
    end

    task automatic apply_stimulus(input logic [FBITS-1:0] data, input logic [DLYW-1:0] dly);
        int start;
        start       = acc_cnt;
        pkt_i       = data;
        delay_i     = dly;
        pkt_valid_i = 1'b1;
        for (int i = 0; i < 4 * FRAME_CYC; i++) begin
            @(negedge clk);
            if (acc_cnt != start) break;
        end
        check_output("accept_timeout", 64'(acc_cnt != start), 64'h1);
        pkt_valid_i = 1'b0;
        pkt_i       = FBITS'($urandom);
        delay_i     = DLYW'($urandom);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [DLYW-1:0] rand_delay();
        case ($urandom % 4)
            0:       return '1;
            1:       return DLYW'($urandom);
            default: return DLYW'($urandom % 4096);
        endcase
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_output("reset_ready", 64'(pkt_ready_o), 64'h1);
        check_output("reset_valid", 64'(pkt_delayed_valid_o), 64'h0);
        check_output("reset_frame", 64'(pkt_delayed_o), 64'h0);

        phase = 1;
        apply_stimulus(pack2(1000, -1000), '0);
        for (int i = 0; i < 889; i++) apply_stimulus('0, '0);

        do_reset();
        phase = 2;
        for (int n = 0; n < 905; n++) apply_stimulus(pack2(100 * (n % 300), -37 * (n % 300)), DLYW'(8'h80));

        phase = 3;
        do_reset();
        apply_stimulus(FBITS'($urandom), '0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 30; i++) apply_stimulus((i == 0) ? pack2(500, 500) : '0, '0);

        phase = 4;
        last_pulse_cyc = -1;
        for (int i = 0; i < 40; i++) apply_stimulus(FBITS'($urandom), rand_delay());

        phase = 5;
        for (int i = 0; i < 4150; i++) begin
            repeat ($urandom % 3) @(negedge clk);
            apply_stimulus(FBITS'($urandom), rand_delay());
        end

        repeat (FRAME_CYC + 4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation did not complete, %0d failures so far", n_fail);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/frac_delay_buffer.md
FRAC_DELAY_BUFFER -- requirements
Module: frac_delay_buffer

Interface
REQ-001 Parameter NUM_CH, default 2: audio channels per frame.
REQ-002 Parameter PKT_WIDTH, default 16: signed two's-complement sample width.
REQ-003 Parameter BUF_DEPTH, default 4096: samples per channel; SHALL be a power of two, else $fatal at elaboration.
REQ-004 Parameter ADDR_WIDTH, default $clog2(BUF_DEPTH): per-channel index width.
REQ-005 Parameter FRAC_WIDTH, default 8: fractional delay bits.
REQ-006 Parameter AVG_DELAY, default 882: integer base delay in samples; SHALL be <= BUF_DEPTH-2, else $fatal.
REQ-007 clk  in  1: single clock (CLK_DSP); all logic on its rising edge.
REQ-008 rst  in  1: reset, asynchronous, active-high.
REQ-009 pkt_i  in  NUM_CH*PKT_WIDTH: input frame; channel c at bits [c*PKT_WIDTH +: PKT_WIDTH].
REQ-010 pkt_valid_i  in  1: pkt_i and delay_i valid.
REQ-011 pkt_ready_o  out  1: block can accept a frame.
REQ-012 delay_i  in  ADDR_WIDTH+FRAC_WIDTH: unsigned extra delay, integer.fraction, from LFO.
REQ-013 pkt_delayed_o  out  NUM_CH*PKT_WIDTH: delayed, interpolated frame, same packing.
REQ-014 pkt_delayed_valid_o  out  1: one-cycle pulse, pkt_delayed_o updated this cycle.

Function
REQ-015 Accept occurs on a cycle with pkt_valid_i && pkt_ready_o; pkt_i and delay_i SHALL be latched then; pkt_valid_i while not ready SHALL be ignored (frame dropped, no state change).
REQ-016 pkt_ready_o SHALL be 1 only in state IDLE.
REQ-017 FSM states IDLE, WR, RD_A, RD_B, MIX, DONE; IDLE->WR on accept; WR->RD_A->RD_B->MIX; MIX->WR (next channel) if ch < NUM_CH-1, else MIX->DONE; DONE->IDLE.
REQ-018 Total delay D = AVG_DELAY*2^FRAC_WIDTH + delay_i, computed one bit wider; if D > (BUF_DEPTH-2)*2^FRAC_WIDTH, clamp to that value; d_int = D>>FRAC_WIDTH, frac = D[FRAC_WIDTH-1:0].
REQ-019 Storage: one synchronous-read RAM of NUM_CH*BUF_DEPTH words, address {ch, index}; at most one access per cycle.
REQ-020 WR: write channel ch sample at {ch, wp}.
REQ-021 RD_A: issue read at wp - d_int (mod BUF_DEPTH); RD_B: capture tap A, issue read at wp - d_int - 1 (mod BUF_DEPTH); MIX: capture tap B.
REQ-022 Wrap-around SHALL be natural ADDR_WIDTH-bit modulo arithmetic.
REQ-023 MIX: y = A + (((B - A) * frac) >>> FRAC_WIDTH); B-A at PKT_WIDTH+1 bits, product at PKT_WIDTH+FRAC_WIDTH+2 bits signed, arithmetic shift (floor); y stored to internal frame register, truncated to PKT_WIDTH (range lies within [A,B], no saturation).
REQ-024 fill_cnt counts completed frames, saturating at BUF_DEPTH; a tap of age k (A: d_int, B: d_int+1) SHALL read as 0 unless k <= fill_cnt (suppresses startup pop).
REQ-025 DONE: copy internal frame register to pkt_delayed_o atomically, pulse pkt_delayed_valid_o, wp <= wp+1, fill_cnt increment.
REQ-026 Latency: accept at cycle T yields pkt_delayed_valid_o at T + 4*NUM_CH + 1; pkt_ready_o returns at T + 4*NUM_CH + 2.
REQ-027 pkt_delayed_o SHALL hold its value between pulses.
REQ-028 delay_i changes mid-frame SHALL NOT affect the frame in progress.

Reset
REQ-029 On rst: state IDLE, wp 0, ch 0, fill_cnt 0, pkt_delayed_o 0, pkt_delayed_valid_o 0, pkt_ready_o 1 (once released); RAM not cleared.
REQ-030 Reset mid-frame SHALL abort the frame with no output pulse; fill_cnt 0 masks stale RAM.

Structure
REQ-031 Package delay_pkg SHALL hold the FSM state enum typedef and the clamp constant function.
REQ-032 Sub-module frac_lerp (combinational: A, B, frac -> y) SHALL implement REQ-023.
REQ-033 RAM SHALL be a separate always_ff block inferable as EBR/SPRAM.

Verification
REQ-034 Impulse: NUM_CH=2, delay_i=0, frame 1 = {1000,-1000}, then zeros -> nonzero output exactly on the 883rd output frame, values {1000,-1000}.
REQ-035 Fraction: delay_i=0x0080 (0.5), ramp input 0,100,200... -> steady-state output = input of 882 frames earlier minus 50.
REQ-036 Clamp: delay_i all ones -> effective d_int = 4094, frac 0; no address beyond channel region.
REQ-037 Startup: first frame 500, delay_i=0 -> outputs 0 until fill_cnt >= 882, never X.
REQ-038 Handshake: pkt_valid_i held high continuously -> accepts spaced exactly 4*NUM_CH+2 cycles; valid pulse width 1.
REQ-039 Reset asserted during RD_B -> no pkt_delayed_valid_o, outputs 0, next accept behaves as REQ-037.
